// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and sizing for the pipeline control block.
package instruction_utils;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_e;
endpackage

// File: rtl/pipeline_ctrl_scoreboard.sv
// Register busy bitmap: tracks in-flight writes and reports RAW/WAW hazards for the ID instruction.
module scoreboard
    import instruction_utils::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic                  rs1_used_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic                  rs2_used_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  rd_wr_en_i,
    input  logic                  set_en_i,
    input  logic                  clr_en_i,
    input  logic [REG_ADDR_W-1:0] clr_addr_i,
    output logic                  hazard_o,
    output logic [NUM_REGS-1:0]   busy_mask_o
);
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_eff;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    function automatic logic reg_pending(input logic [NUM_REGS-1:0] busy,
                                         input logic [REG_ADDR_W-1:0] addr,
                                         input logic used);
        return used && (addr != '0) && busy[addr];
    endfunction

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en_i) set_mask[rd_addr_i] = 1'b1;
        if (clr_en_i) clr_mask[clr_addr_i] = 1'b1;
        // A retiring write frees its register for this cycle's hazard check.
        busy_eff = busy_q & ~clr_mask;
        busy_d = busy_eff | set_mask;
        busy_d[0] = 1'b0;
        hazard_o = reg_pending(busy_eff, rs1_addr_i, rs1_used_i) ||
                   reg_pending(busy_eff, rs2_addr_i, rs2_used_i) ||
                   reg_pending(busy_eff, rd_addr_i, rd_wr_en_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_mask_o = busy_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: issue/stall/flush/hold decisions, FSM for branch flush and memory wait,
// and a saturating stall-cycle counter.
module pipeline_ctrl
    import instruction_utils::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_wr_en,
    input  logic [REG_ADDR_W-1:0] wb_id_rd_addr,
    input  logic                  wb_id_wr_en,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  issue,
    output logic                  stall,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic                  pipe_hold,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic [15:0]           stall_cycles
);
    ctrl_state_e state_q, state_d;
    logic [15:0] stall_cycles_q;
    logic        hazard;
    logic        mem_stall;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1_addr_i  (id_rs1_addr),
        .rs1_used_i  (id_rs1_used),
        .rs2_addr_i  (id_rs2_addr),
        .rs2_used_i  (id_rs2_used),
        .rd_addr_i   (id_rd_addr),
        .rd_wr_en_i  (id_wr_en),
        .set_en_i    (issue && id_wr_en),
        .clr_en_i    (wb_id_wr_en),
        .clr_addr_i  (wb_id_rd_addr),
        .hazard_o    (hazard),
        .busy_mask_o (busy_mask)
    );

    assign mem_stall = dmem_req && !dmem_ready;

    always_comb begin
        issue        = 1'b0;
        stall        = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        pipe_hold    = 1'b0;
        state_d      = state_q;
        if (!rst_n) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
            state_d      = RUN;
        end else if (state_q == FLUSH) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
            state_d      = RUN;
        end else if (state_q == MEM_WAIT && !dmem_ready) begin
            pipe_hold = 1'b1;
            stall     = 1'b1;
        end else begin
            // RUN, or MEM_WAIT releasing this cycle: memory stall outranks branch, branch outranks hazard.
            state_d = RUN;
            if (mem_stall) begin
                pipe_hold = 1'b1;
                stall     = 1'b1;
                state_d   = MEM_WAIT;
            end else if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                state_d      = FLUSH;
            end else if (id_valid && hazard) begin
                stall        = 1'b1;
                id_ex_bubble = 1'b1;
            end else begin
                issue = id_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= RUN;
            stall_cycles_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall) stall_cycles_q <= sat_inc(stall_cycles_q);
        end
    end

    assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: stimulus pushes expected responses, a negedge monitor checks them.
module tb_pipeline_ctrl;
    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, wb_id_rd_addr;
    logic        id_rs1_used, id_rs2_used, id_wr_en, wb_id_wr_en;
    logic        ex_branch_taken, dmem_req, dmem_ready;
    logic        issue, stall, id_ex_bubble, if_id_flush, pipe_hold;
    logic [31:0] busy_mask;
    logic [15:0] stall_cycles;

    pipeline_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_wr_en(id_wr_en),
        .wb_id_rd_addr(wb_id_rd_addr), .wb_id_wr_en(wb_id_wr_en),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .issue(issue), .stall(stall), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .pipe_hold(pipe_hold),
        .busy_mask(busy_mask), .stall_cycles(stall_cycles)
    );

    // ctrl bits: {issue, stall, id_ex_bubble, if_id_flush, pipe_hold}
    localparam logic [4:0] C_ISSUE = 5'b10000;
    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_HAZ   = 5'b01100;
    localparam logic [4:0] C_FLUSH = 5'b00110;
    localparam logic [4:0] C_HOLD  = 5'b01001;
    localparam logic [4:0] C_RST   = 5'b00110;

    typedef struct {
        string       name;
        logic [4:0]  ctrl;
        logic [31:0] busy;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if ({issue, stall, id_ex_bubble, if_id_flush, pipe_hold} !== mon_e.ctrl) begin
                n_fail++;
                $display("FAIL %s ctrl{iss,stl,bub,fl,hold} got %05b want %05b", mon_e.name,
                         {issue, stall, id_ex_bubble, if_id_flush, pipe_hold}, mon_e.ctrl);
            end
            n_cmp++;
            if (busy_mask !== mon_e.busy) begin
                n_fail++;
                $display("FAIL %s busy_mask got %08h want %08h", mon_e.name, busy_mask, mon_e.busy);
            end
            n_cmp++;
            if (stall_cycles !== mon_e.sc) begin
                n_fail++;
                $display("FAIL %s stall_cycles got %0d want %0d", mon_e.name, stall_cycles, mon_e.sc);
            end
        end
    end

    task automatic idle();
        rst_n = 1'b1; id_valid = 1'b0;
        id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_wr_en = 1'b0;
        wb_id_rd_addr = '0; wb_id_wr_en = 1'b0;
        ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic we);
        id_valid = 1'b1;
        id_rs1_addr = rs1; id_rs1_used = u1;
        id_rs2_addr = rs2; id_rs2_used = u2;
        id_rd_addr = rd; id_wr_en = we;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_id_rd_addr = rd; wb_id_wr_en = 1'b1;
    endtask

    task automatic step(input string nm, input logic [4:0] c, input logic [31:0] b,
                        input logic [15:0] s);
        exp_t e;
        e.name = nm; e.ctrl = c; e.busy = b; e.sc = s;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waitc;
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        step("reset_a", C_RST, 32'h0, 16'd0);
        rst_n = 1'b0; instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
        step("reset_b", C_RST, 32'h0, 16'd0);

        // RAW on x5 held until writeback retires it
        idle(); instr(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1); step("addi_x5", C_ISSUE, 32'h0, 16'd0);
        idle(); instr(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1); step("raw_1", C_HAZ, 32'h20, 16'd0);
        step("raw_2", C_HAZ, 32'h20, 16'd1);
        wb(5'd5);                                          step("raw_wb", C_ISSUE, 32'h20, 16'd2);
        idle();                                            step("after_raw", C_IDLE, 32'h40, 16'd2);
        wb(5'd6);                                          step("wb_x6", C_IDLE, 32'h40, 16'd2);

        // x0 never becomes busy
        idle(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1); step("wr_x0", C_ISSUE, 32'h0, 16'd2);
        idle(); instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1); step("rd_x0", C_ISSUE, 32'h0, 16'd2);
        idle();                                            step("x0_idle", C_IDLE, 32'h0, 16'd2);

        // taken branch: two flush cycles, nothing marked busy
        idle(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1); ex_branch_taken = 1'b1;
        step("br_1", C_FLUSH, 32'h0, 16'd2);
        idle(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        step("br_2", C_FLUSH, 32'h0, 16'd2);
        idle();                                            step("br_done", C_IDLE, 32'h0, 16'd2);

        // WAW hazard on destination
        idle(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1); step("wr_x9", C_ISSUE, 32'h0, 16'd2);
        idle(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1); step("waw_x9", C_HAZ, 32'h200, 16'd2);
        idle(); wb(5'd9);                                  step("wb_x9", C_IDLE, 32'h200, 16'd3);
        idle();                                            step("x9_free", C_IDLE, 32'h0, 16'd3);

        // memory stall outranks branch; branch ignored during hold
        idle(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        dmem_req = 1'b1; ex_branch_taken = 1'b1;
        step("mem_1", C_HOLD, 32'h0, 16'd3);
        step("mem_2", C_HOLD, 32'h0, 16'd4);
        step("mem_3", C_HOLD, 32'h0, 16'd5);
        ex_branch_taken = 1'b0; dmem_ready = 1'b1;
        step("mem_rel", C_ISSUE, 32'h0, 16'd6);
        idle(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0); ex_branch_taken = 1'b1;
        step("br_again", C_FLUSH, 32'h10, 16'd6);
        idle(); wb(5'd4);                                  step("flush_wb", C_FLUSH, 32'h10, 16'd6);
        idle();                                            step("flush_done", C_IDLE, 32'h0, 16'd6);

        // same-cycle clear and set of x7: set wins
        idle(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); step("wr_x7", C_ISSUE, 32'h0, 16'd6);
        idle(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); wb(5'd7);
        step("x7_setclr", C_ISSUE, 32'h80, 16'd6);
        idle();                                            step("x7_set", C_IDLE, 32'h80, 16'd6);

        // reset during MEM_WAIT with busy = A0
        idle(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1); step("wr_x5b", C_ISSUE, 32'h80, 16'd6);
        idle(); dmem_req = 1'b1;                           step("mw_1", C_HOLD, 32'hA0, 16'd6);
        step("mw_2", C_HOLD, 32'hA0, 16'd7);
        rst_n = 1'b0; instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1); wb(5'd7);
        step("rst_mw", C_RST, 32'hA0, 16'd8);
        idle(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1); step("post_rst", C_ISSUE, 32'h0, 16'd0);
        idle();                                            step("post_rst2", C_IDLE, 32'h4, 16'd0);

        // stall counter saturation
        idle(); dmem_req = 1'b1;                           step("sat_start", C_HOLD, 32'h4, 16'd0);
        repeat (65533) @(posedge clk);
        #1;
        step("sat_m1", C_HOLD, 32'h4, 16'hFFFE);
        step("sat_max", C_HOLD, 32'h4, 16'hFFFF);
        step("sat_hold", C_HOLD, 32'h4, 16'hFFFF);
        dmem_ready = 1'b1;                                 step("sat_rel", C_IDLE, 32'h4, 16'hFFFF);
        idle();                                            step("sat_end", C_IDLE, 32'h4, 16'hFFFF);

        waitc = 0;
        while (exp_q.size() > 0 && waitc < 20) begin
            @(posedge clk);
            waitc++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain queue left %0d entries want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
